// File: rtl/kulisch_to_float_seq_pkg.sv
// kulisch_to_float_seq_pkg: FSM state codes and width helpers for the Kulisch-to-float converter
package kulisch_to_float_seq_pkg;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ABS   = 3'd1;
    localparam logic [2:0] S_SCAN  = 3'd2;
    localparam logic [2:0] S_NORM  = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_OUT   = 3'd5;

    function automatic int get_bits(input int non_frac, input int frac);
        return non_frac + frac;
    endfunction

    function automatic int get_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic int get_num_chunks(input int bits, input int chunk);
        return (bits + chunk - 1) / chunk;
    endfunction

    function automatic int get_idx_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/kulisch_to_float_seq_lzd.sv
// kulisch_chunk_lzd: combinational leading-one detector over one scan chunk
module kulisch_chunk_lzd
    import kulisch_to_float_seq_pkg::*;
#(
    parameter int CHUNK = 8,
    parameter int PW    = get_idx_width(CHUNK)
) (
    input  logic [CHUNK-1:0] chunk,
    output logic             found,
    output logic [PW-1:0]    pos
);
    // Highest set bit wins because later iterations overwrite earlier ones
    always_comb begin
        found = |chunk;
        pos = '0;
        for (int i = 0; i < CHUNK; i++)
            if (chunk[i]) pos = PW'(i);
    end
endmodule

// File: rtl/kulisch_to_float_seq.sv
// kulisch_to_float_seq: multi-cycle Kulisch accumulator to IEEE-style float read-out (RNE); KULISCH_TO_FLOAT_DENORMAL_EN enables subnormal output
module kulisch_to_float_seq
    import kulisch_to_float_seq_pkg::*;
#(
    parameter int ACC_NON_FRAC = 13,
    parameter int ACC_FRAC     = 12,
    parameter int EXP          = 8,
    parameter int FRAC         = 23,
    parameter int CHUNK        = 8
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          in_is_inf,
    input  logic                                          in_is_overflow,
    input  logic                                          in_overflow_sign,
    input  logic [get_bits(ACC_NON_FRAC, ACC_FRAC)-1:0]   in_bits,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic                                          out_sign,
    output logic [EXP-1:0]                                out_exp,
    output logic [FRAC-1:0]                               out_frac,
    output logic                                          out_inexact
);
    localparam int BITS = get_bits(ACC_NON_FRAC, ACC_FRAC);
    localparam int NCH  = get_num_chunks(BITS, CHUNK);
    localparam int PAD  = NCH * CHUNK;
    localparam int PW   = get_idx_width(CHUNK);
    localparam int IW   = get_idx_width(NCH);
    localparam int QW   = get_idx_width(BITS);
    localparam int W    = BITS + FRAC + 2;
    localparam int BIAS = get_bias(EXP);
    localparam int MAXE = (1 << EXP) - 1;

    logic [2:0]             state;
    logic                   is_inf, is_ovf, ovf_sign, sign, zero;
    logic [BITS-1:0]        raw;
    logic [PAD-1:0]         mag;
    logic [IW-1:0]          idx;
    logic [QW-1:0]          p;
    logic signed [31:0]     e;
    logic [FRAC:0]          mant;
    logic                   guard, sticky;

    logic [CHUNK-1:0]       chunk;
    logic                   found;
    logic [PW-1:0]          pos;
    logic [QW-1:0]          p_next;
    logic [BITS-1:0]        umag;
    logic [W-1:0]           ext;
    logic                   up, carry;
    logic [FRAC+1:0]        r;
    logic signed [31:0]     biased;
    logic                   res_sign, res_inexact;
    logic [EXP-1:0]         res_exp;
    logic [FRAC-1:0]        res_frac;

    assign in_ready  = state == S_IDLE;
    assign out_valid = state == S_OUT;

    // Select the current chunk (MSB chunk first) and map its leading one back to an unpadded bit index
    always_comb begin
        chunk = CHUNK'(mag >> (PAD - CHUNK - CHUNK * int'(idx)));
        p_next = QW'(BITS - CHUNK - CHUNK * int'(idx) + int'(pos));
    end

    kulisch_chunk_lzd #(.CHUNK(CHUNK), .PW(PW)) lzd (
        .chunk(chunk),
        .found(found),
        .pos  (pos)
    );

    // Left-align the magnitude so the leading one lands on the top (hidden) bit
    always_comb begin
        umag = BITS'(mag >> (PAD - BITS));
        ext = W'(umag) << (W - 1 - int'(p));
    end

    // Round-to-nearest-even on the normalized mantissa, folding a carry-out into the exponent
    always_comb begin
        up = guard & (sticky | mant[0]);
        r = {1'b0, mant} + (FRAC+2)'(up);
        carry = r[FRAC+1];
        biased = e + BIAS + int'(carry);
    end

`ifdef KULISCH_TO_FLOAT_DENORMAL_EN
    localparam int L = FRAC + 3;
    logic signed [31:0] dshift;
    logic [2*L-1:0]     wide;
    logic [FRAC:0]      dm, dr;
    logic               dg, ds;

    // Subnormal path: shift mantissa/guard/sticky right by 1-biased, then round again
    always_comb begin
        dshift = 1 - (e + BIAS);
        wide = {mant, guard, sticky, L'(0)} >> (dshift > L ? L : dshift);
        dm = wide[2*L-1 -: FRAC+1];
        dg = wide[L+1];
        ds = |wide[L:0];
        dr = dm + (FRAC+1)'(dg & (ds | dm[0]));
    end
`endif

    // Final result selection; specials override the scanned value
    always_comb begin
        res_sign = sign;
        res_exp = EXP'(biased);
        res_frac = carry ? r[FRAC:1] : r[FRAC-1:0];
        res_inexact = guard | sticky;
        if (is_inf) begin
            res_sign = 1'b0;
            res_exp = '1;
            res_frac = FRAC'(1) << (FRAC - 1);
            res_inexact = 1'b0;
        end else if (is_ovf) begin
            res_sign = ovf_sign;
            res_exp = '1;
            res_frac = '0;
            res_inexact = 1'b1;
        end else if (zero) begin
            res_sign = 1'b0;
            res_exp = '0;
            res_frac = '0;
            res_inexact = 1'b0;
        end else if (biased >= MAXE) begin
            res_exp = '1;
            res_frac = '0;
            res_inexact = 1'b1;
`ifdef KULISCH_TO_FLOAT_DENORMAL_EN
        end else if (e + BIAS <= 0) begin
            res_exp = EXP'(dr[FRAC]);
            res_frac = dr[FRAC-1:0];
            res_inexact = dg | ds;
`else
        end else if (biased <= 0) begin
            res_exp = '0;
            res_frac = '0;
            res_inexact = 1'b1;
`endif
        end
    end

    // Conversion FSM: IDLE -> ABS -> SCAN -> NORM -> ROUND -> OUT
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            is_inf <= 1'b0;
            is_ovf <= 1'b0;
            ovf_sign <= 1'b0;
            sign <= 1'b0;
            zero <= 1'b0;
            raw <= '0;
            mag <= '0;
            idx <= '0;
            p <= '0;
            e <= '0;
            mant <= '0;
            guard <= 1'b0;
            sticky <= 1'b0;
            out_sign <= 1'b0;
            out_exp <= '0;
            out_frac <= '0;
            out_inexact <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    is_inf <= in_is_inf;
                    is_ovf <= in_is_overflow;
                    ovf_sign <= in_overflow_sign;
                    sign <= in_bits[BITS-1];
                    raw <= in_bits;
                    state <= S_ABS;
                end
                S_ABS: begin
                    mag <= PAD'(sign ? -raw : raw) << (PAD - BITS);
                    idx <= '0;
                    zero <= 1'b0;
                    state <= S_SCAN;
                end
                S_SCAN: if (found) begin
                    p <= p_next;
                    state <= S_NORM;
                end else if (idx == IW'(NCH - 1)) begin
                    zero <= 1'b1;
                    state <= S_NORM;
                end else begin
                    idx <= idx + 1'b1;
                end
                S_NORM: begin
                    e <= int'(p) - ACC_FRAC;
                    mant <= ext[W-1 -: FRAC+1];
                    guard <= ext[BITS];
                    sticky <= |ext[BITS-1:0];
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    out_sign <= res_sign;
                    out_exp <= res_exp;
                    out_frac <= res_frac;
                    out_inexact <= res_inexact;
                    state <= S_OUT;
                end
                S_OUT: if (out_ready) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kulisch_to_float_seq.sv
// tb_kulisch_to_float_seq: directed checks of the default converter and a narrow EXP=3/FRAC=3 instance
module tb_kulisch_to_float_seq;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_is_inf = 1'b0, in_is_overflow = 1'b0, in_overflow_sign = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [24:0] in_bits = '0;
    logic        in_ready0, out_valid0, s0, x0;
    logic [7:0]  e0;
    logic [22:0] f0;
    logic        in_ready1, out_valid1, s1, x1;
    logic [2:0]  e1, f1;
    int          checks = 0, failures = 0, lat = 0;

    always #5 clock = ~clock;

    kulisch_to_float_seq dut0 (
        .clock(clock), .reset(reset),
        .in_is_inf(in_is_inf), .in_is_overflow(in_is_overflow), .in_overflow_sign(in_overflow_sign),
        .in_bits(in_bits), .in_valid(in_valid), .in_ready(in_ready0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_sign(s0), .out_exp(e0), .out_frac(f0), .out_inexact(x0)
    );

    kulisch_to_float_seq #(.EXP(3), .FRAC(3)) dut1 (
        .clock(clock), .reset(reset),
        .in_is_inf(in_is_inf), .in_is_overflow(in_is_overflow), .in_overflow_sign(in_overflow_sign),
        .in_bits(in_bits), .in_valid(in_valid), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_sign(s1), .out_exp(e1), .out_frac(f1), .out_inexact(x1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic convert(input logic [24:0] b, input logic inf, input logic ovf, input logic os);
        in_bits = b;
        in_is_inf = inf;
        in_is_overflow = ovf;
        in_overflow_sign = os;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic vec(input string tag, input logic [24:0] b, input logic inf, input logic ovf,
                       input logic os, input int lat_e, input logic [32:0] exp0, input logic [7:0] exp1);
        convert(b, inf, ovf, os);
        chk({tag, "_lat"}, 64'(lat), 64'(lat_e));
        chk({tag, "_d0"}, 64'({s0, e0, f0, inf ? 1'b0 : x0}), 64'(exp0));
        chk({tag, "_d1"}, 64'({out_valid1, s1, e1, f1, inf ? 1'b0 : x1}), 64'({1'b1, exp1}));
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, "_idle"}, 64'({in_ready0, out_valid0}), 64'(2'b10));
    endtask

    initial begin
        #1;
        chk("rst_hs", 64'({in_ready0, out_valid0, in_ready1, out_valid1}), 64'(4'b1010));
        chk("rst_out", 64'({s0, e0, f0, x0, s1, e1, f1, x1}), 64'(0));
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        vec("one",      25'd4096,     0, 0, 0, 5, {1'b0, 8'd127, 23'h000000, 1'b0}, {1'b0, 3'd3, 3'b000, 1'b0});
        vec("neg1p5",   25'h1FFE800,  0, 0, 0, 5, {1'b1, 8'd127, 23'h400000, 1'b0}, {1'b1, 3'd3, 3'b100, 1'b0});
        vec("tiny",     25'd1,        0, 0, 0, 7, {1'b0, 8'd115, 23'h000000, 1'b0}, {1'b0, 3'd0, 3'b000, 1'b1});
        vec("zero",     25'd0,        0, 0, 0, 7, {1'b0, 8'd0,   23'h000000, 1'b0}, {1'b0, 3'd0, 3'b000, 1'b0});
        vec("ovf",      25'd4096,     0, 1, 1, 5, {1'b1, 8'd255, 23'h000000, 1'b1}, {1'b1, 3'd7, 3'b000, 1'b1});
        vec("inf",      25'd0,        1, 0, 0, 7, {1'b0, 8'd255, 23'h400000, 1'b0}, {1'b0, 3'd7, 3'b100, 1'b0});
        vec("tie_up",   25'd4864,     0, 0, 0, 5, {1'b0, 8'd127, 23'h180000, 1'b0}, {1'b0, 3'd3, 3'b010, 1'b1});
        vec("tie_even", 25'd4352,     0, 0, 0, 5, {1'b0, 8'd127, 23'h080000, 1'b0}, {1'b0, 3'd3, 3'b000, 1'b1});
        vec("carry",    25'd7936,     0, 0, 0, 5, {1'b0, 8'd127, 23'h780000, 1'b0}, {1'b0, 3'd4, 3'b000, 1'b1});
`ifdef KULISCH_TO_FLOAT_DENORMAL_EN
        vec("small",    25'd128,      0, 0, 0, 6, {1'b0, 8'd122, 23'h000000, 1'b0}, {1'b0, 3'd0, 3'b001, 1'b0});
`else
        vec("small",    25'd128,      0, 0, 0, 6, {1'b0, 8'd122, 23'h000000, 1'b0}, {1'b0, 3'd0, 3'b000, 1'b1});
`endif
        vec("big",      25'h0100000,  0, 0, 0, 4, {1'b0, 8'd135, 23'h000000, 1'b0}, {1'b0, 3'd7, 3'b000, 1'b1});
        vec("maxneg",   25'h1000000,  0, 0, 0, 4, {1'b1, 8'd139, 23'h000000, 1'b0}, {1'b1, 3'd7, 3'b000, 1'b1});

        in_is_inf = 1'b0;
        in_is_overflow = 1'b0;
        in_overflow_sign = 1'b0;
        in_bits = 25'd4096;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_bits = 25'd128;
        lat = 0;
        while (!out_valid0 && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall", 64'({out_valid0, in_ready0, s0, e0, f0, x0}), 64'({1'b1, 1'b0, 1'b0, 8'd127, 23'h0, 1'b0}));
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("stall_done", 64'({in_ready0, out_valid0}), 64'(2'b10));

        in_bits = 25'd0;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        chk("abort_out", 64'({s0, e0, f0, x0}), 64'(0));
        for (int i = 0; i < 8; i++) begin
            chk("abort_hs", 64'({in_ready0, out_valid0}), 64'(2'b10));
            @(posedge clock); #1;
        end
        vec("after_rst", 25'd4096,    0, 0, 0, 5, {1'b0, 8'd127, 23'h000000, 1'b0}, {1'b0, 3'd3, 3'b000, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
